// File: rtl/spi_ip_crc_serial_pkg.sv
// Shared SPI CRC package: width-select encodings, register width and the
// reset/init value used by the serial CRC generator/checker.
package spi_ip_crc_serial_pkg;

    localparam int unsigned CRC_W = 16;

    localparam logic CRC_8  = 1'b0;
    localparam logic CRC_16 = 1'b1;

    localparam logic [CRC_W-1:0] CRC_INIT = 16'h0000;

endpackage : spi_ip_crc_serial_pkg

// File: rtl/spi_ip_crc_serial_chk.sv
// Simulation-only protocol checks for spi_ip_crc_serial. The body is only
// compiled when SPI_CRC_ASSERT_EN is defined.
`ifdef SPI_CRC_ASSERT_EN
module spi_ip_crc_serial_chk (
    input logic        clk,
    input logic        rst_n,
    input logic        crc_in,
    input logic        enable,
    input logic        init,
    input logic        size,
    input logic [15:0] poly
);

    // Width and polynomial must stay put across consecutive shifting edges.
    a_cfg_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (enable && $past(enable)) |-> ($stable(size) && $stable(poly)))
        else $error("crc_chk: size/poly changed while shifting");

    // A shifted-in data bit must be a known value.
    a_din_known: assert property (@(posedge clk) disable iff (!rst_n)
        enable |-> !$isunknown(crc_in))
        else $error("crc_chk: X on data bit while enabled");

    // Control inputs must be known once out of reset.
    a_ctl_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({init, enable}))
        else $error("crc_chk: X on init/enable");

endmodule : spi_ip_crc_serial_chk
`endif

// File: rtl/spi_ip_crc_step.sv
// One Galois-LFSR step of the programmable CRC, purely combinational so a
// parallel or byte-wise CRC can chain several instances.
module spi_ip_crc_step
    import spi_ip_crc_serial_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic        bit_i,
    input  logic [15:0] poly_i,
    input  logic        size_i,
    output logic [15:0] crc_o
);

    logic       fb16_s;
    logic       fb8_s;
    logic [7:0] low8_s;

    // Compute feedback and the next register value for the selected width.
    always_comb begin
        fb16_s = bit_i ^ crc_i[15];
        fb8_s  = bit_i ^ crc_i[7];
        low8_s = 8'h00;
        crc_o  = 16'h0000;
        if (size_i == CRC_16) begin
            crc_o = {crc_i[14:0], 1'b0} ^ (fb16_s ? poly_i : 16'h0000);
        end else begin
            // CRC-8 ignores the upper polynomial byte and forces the upper byte to zero.
            low8_s = {crc_i[6:0], 1'b0} ^ (fb8_s ? poly_i[7:0] : 8'h00);
            crc_o  = {8'h00, low8_s};
        end
    end

endmodule : spi_ip_crc_step

// File: rtl/spi_ip_crc_serial.sv
// Bit-serial CRC-8/CRC-16 generator/checker for the SPI IP.
// Optional simulation checks: define SPI_CRC_ASSERT_EN.
module spi_ip_crc_serial
    import spi_ip_crc_serial_pkg::*;
(
    input  logic        cs_clk_i,
    input  logic        cs_rst_n_i,
    input  logic        cs_crc_in_i,
    input  logic        cs_crc_enable_i,
    input  logic        cs_crc_init_i,
    input  logic        cs_crc_size_i,
    input  logic [15:0] cs_crc_poly_i,
    output logic [15:0] cs_crc_out_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic [15:0] step_s;

    spi_ip_crc_step u_step (
        .crc_i  (crc_q),
        .bit_i  (cs_crc_in_i),
        .poly_i (cs_crc_poly_i),
        .size_i (cs_crc_size_i),
        .crc_o  (step_s)
    );

    // Next-state selection: init beats enable, otherwise hold.
    always_comb begin
        crc_d = crc_q;
        if (cs_crc_init_i) begin
            crc_d = CRC_INIT;
        end else if (cs_crc_enable_i) begin
            crc_d = step_s;
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register with asynchronous active-low reset.
    always_ff @(posedge cs_clk_i or negedge cs_rst_n_i) begin
        if (!cs_rst_n_i) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign cs_crc_out_o = crc_q;

`ifdef SPI_CRC_ASSERT_EN
    spi_ip_crc_serial_chk u_chk (
        .clk    (cs_clk_i),
        .rst_n  (cs_rst_n_i),
        .crc_in (cs_crc_in_i),
        .enable (cs_crc_enable_i),
        .init   (cs_crc_init_i),
        .size   (cs_crc_size_i),
        .poly   (cs_crc_poly_i)
    );
`else
`endif

endmodule : spi_ip_crc_serial

// File: tb/tb_spi_ip_crc_serial.sv
// Self-checking bench for spi_ip_crc_serial: directed vectors plus random
// frames checked against a polynomial long-division reference.
module tb_spi_ip_crc_serial;

    logic        clk;
    logic        rst_n;
    logic        din;
    logic        en;
    logic        init;
    logic        size;
    logic [15:0] poly;
    logic [15:0] crc_out;

    int tests;
    int fails;

    spi_ip_crc_serial dut (
        .cs_clk_i        (clk),
        .cs_rst_n_i      (rst_n),
        .cs_crc_in_i     (din),
        .cs_crc_enable_i (en),
        .cs_crc_init_i   (init),
        .cs_crc_size_i   (size),
        .cs_crc_poly_i   (poly),
        .cs_crc_out_o    (crc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: remainder of (message * x^W) divided by (x^W + poly),
    // first-presented bit is the highest-order message coefficient.
    function automatic logic [15:0] ref_crc(input logic [31:0] data, input int n,
                                            input logic sz, input logic [15:0] p);
        int          w;
        logic [16:0] g;
        logic [16:0] rem;
        logic        b;
        w   = sz ? 16 : 8;
        g   = (17'd1 << w) | {1'b0, (sz ? p : {8'h00, p[7:0]})};
        rem = 17'd0;
        for (int i = 0; i < n + w; i++) begin
            b   = (i < n) ? data[i] : 1'b0;
            rem = {rem[15:0], b};
            if (rem[w]) rem = rem ^ g;
        end
        return rem[15:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        tests++;
        assert (crc_out === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, crc_out, exp);
        end
    endtask

    // One clock with the given controls; outputs settle by the following negedge.
    task automatic cycle(input logic e, input logic i, input logic b);
        @(negedge clk);
        en   = e;
        init = i;
        din  = b;
        @(posedge clk);
        @(negedge clk);
        en   = 1'b0;
        init = 1'b0;
        din  = 1'b0;
    endtask

    // Feed n bits LSB first, optionally with random idle gaps between bits.
    task automatic feed(input logic [31:0] data, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) cycle(1'b0, 1'b0, ~data[k]);
            cycle(1'b1, 1'b0, data[k]);
        end
    endtask

    task automatic frame(input string tag, input logic sz, input logic [15:0] p,
                         input logic [31:0] data, input int n, input bit gaps,
                         input logic [15:0] exp);
        size = sz;
        poly = p;
        cycle(1'b0, 1'b1, 1'b0);
        feed(data, n, gaps);
        check(tag, exp);
    endtask

    logic [31:0] rdata;
    logic [15:0] rpoly;
    logic        rsz;
    int          rn;
    logic [15:0] held;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        din   = 1'b0;
        en    = 1'b0;
        init  = 1'b0;
        size  = 1'b0;
        poly  = 16'h0000;

        // Reset held for two clocks.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 16'h0000);
        rst_n = 1'b1;

        // CRC-8 poly 0x03 over 0xAB, straight out of reset (no init).
        size = 1'b0;
        poly = 16'h0003;
        feed(32'h0000_00AB, 8, 1'b0);
        check("crc8_p03_AB", 16'h007C);
        check("crc8_p03_AB_ref", ref_crc(32'hAB, 8, 1'b0, 16'h0003));

        frame("crc8_p83_77", 1'b0, 16'h0083, 32'h77, 8, 1'b0, 16'h005F);
        frame("crc8_pC3_77", 1'b0, 16'h00C3, 32'h77, 8, 1'b0, 16'h005B);
        frame("crc16_p0083", 1'b1, 16'h0083, 32'h7777, 16, 1'b0, 16'h7FA8);
        frame("crc16_pC083", 1'b1, 16'hC083, 32'h7777, 16, 1'b0, 16'h6826);
        frame("crc16_pFFFF", 1'b1, 16'hFFFF, 32'h7777, 16, 1'b1, 16'h7777);

        // Hold with enable low for five cycles.
        held = 16'h7777;
        repeat (5) cycle(1'b0, 1'b0, 1'b1);
        check("hold", held);

        // Init and enable together: init wins, bit discarded.
        cycle(1'b1, 1'b1, 1'b1);
        check("init_over_en", 16'h0000);

        // CRC-8 ignores upper poly byte and keeps upper output byte zero.
        frame("crc8_pFF83", 1'b0, 16'hFF83, 32'h77, 8, 1'b0, 16'h005F);

        // Check mode: data followed by its CRC (MSB of CRC first) leaves zero.
        frame("crc16_chk", 1'b1, 16'h1021,
              {16'h0000, 16'h0000}, 0, 1'b0, 16'h0000);
        rdata = 32'h0000_5A3C;
        held  = ref_crc(rdata, 16, 1'b1, 16'h1021);
        for (int k = 0; k < 16; k++) rdata[16 + k] = held[15 - k];
        frame("crc16_residue", 1'b1, 16'h1021, rdata, 32, 1'b0, 16'h0000);

        // Randomised frames against the reference.
        for (int t = 0; t < 12; t++) begin
            rsz   = 1'($urandom_range(0, 1));
            rpoly = 16'($urandom);
            rdata = $urandom;
            rn    = $urandom_range(1, 32);
            frame("random", rsz, rpoly, rdata, rn, 1'b1, ref_crc(rdata, rn, rsz, rpoly));
        end

        // Asynchronous reset mid-frame clears without a clock edge.
        size = 1'b1;
        poly = 16'h8005;
        cycle(1'b0, 1'b1, 1'b0);
        feed(32'h0000_00F1, 5, 1'b0);
        check("pre_async", ref_crc(32'hF1, 5, 1'b1, 16'h8005));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 16'h0000);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset", 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_spi_ip_crc_serial

// File: doc/spi_ip_crc_serial.md
# spi_ip_crc_serial

Bit-serial CRC generator/checker for the SPI IP. It processes one data bit per enabled clock into a Galois-style LFSR with a run-time programmable polynomial. It supports CRC-8 and CRC-16 widths and sits beside the SPI shift register, which feeds it the same bit stream that goes on or comes off the wire.

## Interface
Parameters: none. Width and polynomial are selected at run time.

Ports:
- cs_clk_i  in  1  clock; all state updates on the rising edge.
- cs_rst_n_i  in  1  reset. One clock; reset is asynchronous and active-low.
- cs_crc_in_i  in  1  serial data bit, sampled on the rising edge when enabled.
- cs_crc_enable_i  in  1  shift-enable; one bit is absorbed per rising edge while high.
- cs_crc_init_i  in  1  synchronous clear of the CRC register.
- cs_crc_size_i  in  1  width select: 0 = CRC-8, 1 = CRC-16.
- cs_crc_poly_i  in  16  generator polynomial without the implicit top term. In CRC-8 mode only bits [7:0] are used.
- cs_crc_out_o  out  16  current CRC register, driven directly from flops. In CRC-8 mode bits [15:8] read 0.

## Operation
- State is a 16-bit register `crc`.
- Per rising edge, priority is highest first:
  1. Reset: `crc` = 0x0000, asynchronously.
  2. Init high: `crc` = 0x0000. This takes priority over enable; an input bit presented in the same cycle is discarded.
  3. Enable high: one LFSR step.
  4. Otherwise: hold.
- CRC-16 step:
  - fb = cs_crc_in_i XOR crc[15]
  - crc = (crc << 1)[15:0] XOR (fb ? poly[15:0] : 0)
- CRC-8 step:
  - fb = cs_crc_in_i XOR crc[7]
  - crc[7:0] = (crc[7:0] << 1)[7:0] XOR (fb ? poly[7:0] : 0)
  - crc[15:8] = 0
- No final XOR, no bit reflection, initial value 0. Bit order is whatever the caller presents; the SPI core feeds LSB first.
- cs_crc_size_i and cs_crc_poly_i are read combinationally on every step and are not latched. They must be held stable for a whole frame.
- Switching size mid-frame is not supported. The result is defined only by the step equations above: entering CRC-8 mode zeroes the upper byte on the next step.
- Check usage: feed the received data plus the received CRC; a zero remainder means no error.

## Timing
- Zero-cycle output latency: cs_crc_out_o reflects the register updated at the same edge.
- An N-bit frame needs N consecutive (or non-consecutive) enabled edges. The result is valid right after the last enabled edge and holds indefinitely while enable and init are low.
- Init takes effect one edge after it is asserted (synchronous); a single-cycle pulse suffices.
- Reset asserted mid-frame clears the register immediately; the frame is lost.
- Reset value of cs_crc_out_o is 0x0000.

## Configuration
- SPI_CRC_ASSERT_EN defined: simulation-only checks are compiled in.
  - cs_crc_size_i and cs_crc_poly_i must not change while cs_crc_enable_i is high.
  - No X on cs_crc_in_i when enabled.
  - No X on cs_crc_init_i or cs_crc_enable_i out of reset.
  - A violation issues $error.
- SPI_CRC_ASSERT_EN not defined: no checks are compiled. Synthesised logic is identical in both cases.

## Structure
- Shared SPI package holds:
  - width-select encodings CRC_8 = 1'b0 and CRC_16 = 1'b1
  - CRC register width constant (16)
  - reset/init value constant (16'h0000)
- One natural sub-module: spi_ip_crc_step. It is purely combinational, takes (crc, in bit, poly, size) and returns the next crc value, so it can be reused by a future parallel or byte-wise CRC.
- The top level holds the register, reset/init/enable priority and the optional assertions.

## Test plan
- Reset: hold cs_rst_n_i low for 2 clocks -> cs_crc_out_o = 0x0000.
- CRC-8, poly 0x0003, bits of 0xAB LSB first (8 enabled edges) -> 0x007C.
- Init pulse, then CRC-8 with data 0x77 LSB first:
  - poly 0x0083 -> 0x005F
  - after another init, poly 0x00C3 -> 0x005B
- Init, then CRC-16 with data 0x7777 LSB first (16 edges):
  - poly 0x0083 -> 0x7FA8
  - poly 0xC083 -> 0x6826
  - poly 0xFFFF -> 0x7777
- Hold and priority:
  - After a result, keep enable low 5 cycles -> value unchanged.
  - Assert init and enable together -> 0x0000.
  - Assert reset mid-frame -> 0x0000 immediately, without waiting for a clock edge.
- CRC-8 with poly 0xFF83 -> same result as poly 0x0083 (0x005F) and upper byte 0. With SPI_CRC_ASSERT_EN defined, toggling size during a frame -> $error reported.
